// File: rtl/fp_mul_in_stage_if.sv
// Handshake bundle for the fp_mul operand front-end: upstream operand push side
// and downstream head-entry side with precomputed sign/bypass side-band fields.
interface fp_mul_in_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_sign;
  logic        out_bypass;
  logic [31:0] out_bypass_val;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_sign, out_bypass, out_bypass_val
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_sign, out_bypass, out_bypass_val
  );
endinterface

// File: rtl/fp_mul_in_stage.sv
// Operand FIFO in front of fp_mul: classifies each pair on enqueue and stores the
// result sign plus any special-case / exponent-range bypass result alongside it.
module fp_mul_in_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  fp_mul_in_stage_if.slave         bus,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} op_class_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        bypass;
    logic [31:0] bypass_val;
  } entry_t;

  function automatic op_class_e classify(input logic [31:0] x);
    if (x[30:23] == 8'd0)       return CLS_ZERO;  // denormals flush to zero
    else if (x[30:23] != 8'hFF) return CLS_NORM;
    else if (x[22:0] == 23'd0)  return CLS_INF;
    else                        return CLS_NAN;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          in_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;
  op_class_e       cls_a, cls_b;
  logic [8:0]      esum;

  // NOTE: every signal assigned in an always_comb gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cls_a               = classify(bus.in_a);
    cls_b               = classify(bus.in_b);
    esum                = {1'b0, bus.in_a[30:23]} + {1'b0, bus.in_b[30:23]};
    in_entry.a          = bus.in_a;
    in_entry.b          = bus.in_b;
    in_entry.sign       = bus.in_a[31] ^ bus.in_b[31];
    in_entry.bypass     = 1'b1;
    in_entry.bypass_val = 32'h0;

    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      in_entry.bypass_val = 32'h7FC0_0000;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      in_entry.bypass_val = {in_entry.sign, 8'hFF, 23'h0};
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      in_entry.bypass_val = {in_entry.sign, 31'h0};
    end else if (esum <= 9'd127) begin
      in_entry.bypass_val = {in_entry.sign, 31'h0};
    end else if (esum >= 9'd382) begin
      // esum == 381 may still carry into exp 255 inside fp_mul; downstream owns that.
      in_entry.bypass_val = {in_entry.sign, 8'hFF, 23'h0};
    end else begin
      in_entry.bypass     = 1'b0;
    end
  end

  always_comb begin
    push     = bus.in_valid && bus.in_ready;
    pop      = bus.out_valid && bus.out_ready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is only observable after it is written,
  // and leaving the array unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= in_entry;
  end

  assign head               = mem_q[rd_ptr_q];
  assign bus.in_ready       = (count_q < CW'(DEPTH));
  assign bus.out_valid      = (count_q != '0);
  assign bus.out_a          = head.a;
  assign bus.out_b          = head.b;
  assign bus.out_sign       = head.sign;
  assign bus.out_bypass     = head.bypass;
  assign bus.out_bypass_val = head.bypass_val;
  assign count              = count_q;
endmodule

// File: tb/tb_fp_mul_in_stage.sv
// Bench for fp_mul_in_stage: directed vector table, FIFO corner sequences, and a
// randomized run scored against a queue-based behavioural model.
module tb_fp_mul_in_stage;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] count;

  fp_mul_in_stage_if bus ();

  fp_mul_in_stage #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        bypass;
    logic [31:0] val;
  } vec_t;

  typedef struct packed {
    logic        sign;
    logic        bypass;
    logic [31:0] val;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Behavioural reference: IEEE class rules and bias arithmetic on plain integers.
  function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b);
    int   ea = int'(a[30:23]);
    int   eb = int'(b[30:23]);
    bit   za = (ea == 0), zb = (eb == 0);
    bit   ia = (ea == 255) && (a[22:0] == 0), ib = (eb == 255) && (b[22:0] == 0);
    bit   na = (ea == 255) && (a[22:0] != 0), nb = (eb == 255) && (b[22:0] != 0);
    res_t r;
    r.sign   = a[31] ^ b[31];
    r.bypass = 1'b1;
    if (na || nb || (ia && zb) || (za && ib)) r.val = 32'h7FC0_0000;
    else if (ia || ib)                        r.val = {r.sign, 31'h7F80_0000};
    else if (za || zb)                        r.val = {r.sign, 31'h0};
    else if (ea + eb - 127 <= 0)              r.val = {r.sign, 31'h0};
    else if (ea + eb - 127 >= 255)            r.val = {r.sign, 31'h7F80_0000};
    else begin
      r.bypass = 1'b0;
      r.val    = 32'h0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f = 23'($urandom);
    case ($urandom_range(0, 5))
      0:       e = 8'd0;
      1: begin e = 8'hFF; f = 23'd0; end
      2: begin e = 8'hFF; f = 23'($urandom_range(1, 23'h7F_FFFF)); end
      3:       e = 8'($urandom_range(1, 70));
      4:       e = 8'($urandom_range(190, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    return {1'($urandom), e, f};
  endfunction

  vec_t  vecs [13];
  pair_t q [$];
  res_t  r;

  initial begin
    vecs[0]  = '{32'h3F80_0000, 32'hC040_0000, 1'b1, 1'b0, 32'h0000_0000};
    vecs[1]  = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h7FC0_0000};
    vecs[2]  = '{32'h7F80_0000, 32'hBF80_0000, 1'b1, 1'b1, 32'hFF80_0000};
    vecs[3]  = '{32'h8000_0000, 32'h3F80_0000, 1'b1, 1'b1, 32'h8000_0000};
    vecs[4]  = '{32'h7FC0_0001, 32'h0000_0000, 1'b0, 1'b1, 32'h7FC0_0000};
    vecs[5]  = '{32'h3F00_0000, 32'h0080_0000, 1'b0, 1'b1, 32'h0000_0000};
    vecs[6]  = '{32'h7F00_0000, 32'h7F80_0001, 1'b0, 1'b1, 32'h7FC0_0000};
    vecs[7]  = '{32'h7F00_0000, 32'h7F7F_FFFF, 1'b0, 1'b1, 32'h7F80_0000};
    vecs[8]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h3F80_0000, 32'h8080_0000, 1'b1, 1'b0, 32'h0000_0000}; // esum 128
    vecs[10] = '{32'h7F00_0000, 32'h3F80_0000, 1'b0, 1'b0, 32'h0000_0000}; // esum 381
    vecs[11] = '{32'h7F00_0000, 32'hC000_0000, 1'b1, 1'b1, 32'hFF80_0000}; // esum 382
    vecs[12] = '{32'h0000_0001, 32'hBF80_0000, 1'b1, 1'b1, 32'h8000_0000}; // denormal

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_count",     32'(count),         32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd1 - 32'd1);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);

    // Directed classification table: push, inspect head, pop.
    foreach (vecs[i]) begin
      push_one(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_valid", i),  32'(bus.out_valid),  32'd1);
      check($sformatf("v%0d_count", i),  32'(count),          32'd1);
      check($sformatf("v%0d_a", i),      bus.out_a,           vecs[i].a);
      check($sformatf("v%0d_b", i),      bus.out_b,           vecs[i].b);
      check($sformatf("v%0d_sign", i),   32'(bus.out_sign),   32'(vecs[i].sign));
      check($sformatf("v%0d_bypass", i), 32'(bus.out_bypass), 32'(vecs[i].bypass));
      if (vecs[i].bypass)
        check($sformatf("v%0d_val", i), bus.out_bypass_val, vecs[i].val);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("v%0d_pop_count", i), 32'(count), 32'd0);
    end

    // Fill past full with consumer stalled: only DEPTH pairs are taken.
    for (int i = 1; i <= 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = 32'(i);
      bus.in_b     = 32'(i + 100);
      tick();
      check($sformatf("fill_count_%0d", i), 32'(count), 32'((i < DEPTH) ? i : DEPTH));
    end
    bus.in_valid = 1'b0;
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_a_%0d", i), bus.out_a, 32'(i));
      check($sformatf("drain_b_%0d", i), bus.out_b, 32'(i + 100));
      tick();
    end
    bus.out_ready = 1'b0;
    check("drained_valid", 32'(bus.out_valid), 32'd0);

    // Second fill wraps the pointers; a pop at full must not admit a push that cycle.
    for (int i = 7; i <= 10; i++) push_one(32'(i), 32'(i));
    check("refill_count", 32'(count), 32'd4);
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd99;
    bus.in_b      = 32'd99;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    check("pop_at_full_count", 32'(count), 32'd3);
    for (int i = 8; i <= 10; i++) begin
      check($sformatf("wrap_a_%0d", i), bus.out_a, 32'(i));
      tick();
    end
    bus.out_ready = 1'b0;
    check("wrap_empty_count", 32'(count), 32'd0);

    // Simultaneous push and pop at count 2, then push-only at empty with out_ready high.
    push_one(32'd11, 32'd0);
    push_one(32'd12, 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd13;
    bus.out_ready = 1'b1;
    check("simul_head_before", bus.out_a, 32'd11);
    tick();
    check("simul_count", 32'(count), 32'd2);
    check("simul_head_after", bus.out_a, 32'd12);
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("simul_drained", 32'(count), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd14;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("empty_push_count", 32'(count), 32'd1);
    check("empty_push_head", bus.out_a, 32'd14);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Mid-stream reset with a concurrent offered pair.
    for (int i = 21; i <= 23; i++) push_one(32'(i), 32'(i));
    check("pre_reset_count", 32'(count), 32'd3);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd24;
    tick();
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_count",     32'(count),         32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    tick();
    check("midrst_not_stored", 32'(count), 32'd0);

    // Randomized traffic against the queue model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit exp_push, exp_pop;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = rand_op();
      bus.in_b      = rand_op();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      exp_push = bus.in_valid && (q.size() < DEPTH);
      exp_pop  = bus.out_ready && (q.size() != 0);
      check("rnd_in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
      check("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      if (exp_pop) begin
        r = ref_model(q[0].a, q[0].b);
        check("rnd_a",      bus.out_a,           q[0].a);
        check("rnd_b",      bus.out_b,           q[0].b);
        check("rnd_sign",   32'(bus.out_sign),   32'(r.sign));
        check("rnd_bypass", 32'(bus.out_bypass), 32'(r.bypass));
        if (r.bypass) check("rnd_val", bus.out_bypass_val, r.val);
      end
      tick();
      if (exp_pop)  void'(q.pop_front());
      if (exp_push) q.push_back('{bus.in_a, bus.in_b});
      check("rnd_count", 32'(count), 32'(q.size()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
